// File: rtl/toy_bpu_btb_upd_buffer_pkg.sv
// Shared BP DEC / BTB types and sizing for the BTB training-update buffer.
package toy_bpu_btb_upd_buffer_pkg;

    localparam int ENTRY_BUFFER_NUM       = 4;
    localparam int ENTRY_BUFFER_PTR_WIDTH = $clog2(ENTRY_BUFFER_NUM);
    localparam int BTB_UPD_STARVE_MAX     = 8;

    localparam int BTB_INDEX_W = 6;
    localparam int BTB_TAG_W   = 10;
    localparam int BTB_WAY_W   = 2;
    localparam int BTB_ENTRY_W = 32;

    // One BTB training update as produced by BP DEC.
    typedef struct packed {
        logic [BTB_INDEX_W-1:0] index;
        logic [BTB_TAG_W-1:0]   tag;
        logic [BTB_WAY_W-1:0]   way_hit;
        logic [BTB_ENTRY_W-1:0] entry;
        logic                   real_taken;
    } btb_entry_buffer_pkg;

endpackage

// File: rtl/toy_bpu_btb_upd_buffer.sv
// Circular write-back buffer of BTB training updates. Drains oldest-first
// into idle BTB SRAM slots and exposes every slot for the BTB bypass path.
module toy_bpu_btb_upd_buffer
    import toy_bpu_btb_upd_buffer_pkg::*;
#(
    parameter int ENTRY_NUM  = ENTRY_BUFFER_NUM,
    parameter int PTR_WIDTH  = $clog2(ENTRY_NUM),
    parameter int STARVE_MAX = BTB_UPD_STARVE_MAX
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 alloc_vld,
    input  btb_entry_buffer_pkg                  alloc_pld,
    input  logic                                 clear,
    output btb_entry_buffer_pkg [ENTRY_NUM-1:0]  entry_buffer_pld,
    output logic [PTR_WIDTH:0]                   entry_buffer_ptr,
    output logic [ENTRY_NUM-1:0]                 entry_buffer_ena,
    input  logic                                 btb_update_free,
    output logic                                 btb_update_req,
    output btb_entry_buffer_pkg                  btb_update_pld,
    output logic                                 pcgen_hold,
    output logic [PTR_WIDTH:0]                   count
);

    localparam int SW = $clog2(STARVE_MAX) + 1;

    btb_entry_buffer_pkg [ENTRY_NUM-1:0] slot;
    logic [ENTRY_NUM-1:0]                ena;
    logic [ENTRY_NUM-1:0]                ena_nxt;
    logic [PTR_WIDTH:0]                  wptr;
    logic [PTR_WIDTH:0]                  rptr;
    logic [SW-1:0]                       starve;
    logic                                hold;

    logic                                empty;
    logic                                full;
    logic                                push;
    logic                                pop;
    logic                                drop;
    logic [PTR_WIDTH-1:0]                wr_idx;
    logic [PTR_WIDTH-1:0]                rd_idx;

    assign wr_idx = wptr[PTR_WIDTH-1:0];
    assign rd_idx = rptr[PTR_WIDTH-1:0];
    assign empty  = (wptr == rptr);
    assign full   = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) && (wr_idx == rd_idx);

    // Head is offered purely from registered state, so an entry pushed this
    // cycle can never be written to the BTB in the same cycle.
    assign btb_update_req = ~empty;
    assign pop            = btb_update_req & btb_update_free;
    assign push           = alloc_vld & ~clear;
    // Buffer full with nothing draining: oldest entry is sacrificed.
    assign drop           = full & push & ~pop;

    // Slot valid next-state: retire head first, then mark the new tail, so a
    // full-buffer push into the just-retired slot leaves it valid.
    always_comb begin
        ena_nxt = ena;
        if (pop || drop) ena_nxt[rd_idx] = 1'b0;
        if (push)        ena_nxt[wr_idx] = 1'b1;
    end

    // Pointers and valid bits; clear re-bases rptr onto wptr so wptr stays
    // exact for the bypass ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            ena  <= '0;
        end else if (clear) begin
            rptr <= wptr;
            ena  <= '0;
        end else begin
            ena <= ena_nxt;
            if (push)        wptr <= wptr + 1'b1;
            if (pop || drop) rptr <= rptr + 1'b1;
        end
    end

    // Payload storage; invalid slots keep their stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (push) begin
            slot[wr_idx] <= alloc_pld;
        end
    end

    // Starvation tracking: after STARVE_MAX stalled cycles, steal one pcgen
    // slot so the head is guaranteed an idle SRAM cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
            hold   <= 1'b0;
        end else if (pop || clear || empty) begin
            starve <= '0;
            hold   <= 1'b0;
        end else if (starve == SW'(STARVE_MAX - 1)) begin
            starve <= '0;
            hold   <= 1'b1;
        end else begin
            if (starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
            hold <= 1'b0;
        end
    end

    assign entry_buffer_pld = slot;
    assign entry_buffer_ptr = wptr;
    assign entry_buffer_ena = ena;
    assign btb_update_pld   = slot[rd_idx];
    assign pcgen_hold       = hold;
    assign count            = wptr - rptr;

endmodule

// File: tb/tb_toy_bpu_btb_upd_buffer.sv
// Bench for the BTB update buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_toy_bpu_btb_upd_buffer;
    import toy_bpu_btb_upd_buffer_pkg::*;

    localparam int N  = ENTRY_BUFFER_NUM;
    localparam int PW = ENTRY_BUFFER_PTR_WIDTH;
    localparam int SM = BTB_UPD_STARVE_MAX;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic alloc_vld = 1'b0;
    logic clear = 1'b0;
    logic btb_update_free = 1'b0;
    btb_entry_buffer_pkg alloc_pld = '0;

    btb_entry_buffer_pkg [N-1:0] entry_buffer_pld;
    logic [PW:0]                 entry_buffer_ptr;
    logic [N-1:0]                entry_buffer_ena;
    logic                        btb_update_req;
    btb_entry_buffer_pkg         btb_update_pld;
    logic                        pcgen_hold;
    logic [PW:0]                 count;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    toy_bpu_btb_upd_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_vld        (alloc_vld),
        .alloc_pld        (alloc_pld),
        .clear            (clear),
        .entry_buffer_pld (entry_buffer_pld),
        .entry_buffer_ptr (entry_buffer_ptr),
        .entry_buffer_ena (entry_buffer_ena),
        .btb_update_free  (btb_update_free),
        .btb_update_req   (btb_update_req),
        .btb_update_pld   (btb_update_pld),
        .pcgen_hold       (pcgen_hold),
        .count            (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic btb_entry_buffer_pkg mk(input int k, input bit taken);
        btb_entry_buffer_pkg p;
        p.index      = 6'(k * 3 + 1);
        p.tag        = 10'(16'h100 + k);
        p.way_hit    = 2'(k);
        p.entry      = 32'hA000_0000 + 32'(k);
        p.real_taken = taken;
        return p;
    endfunction

    // ---------------- reference model ----------------
    btb_entry_buffer_pkg q[$];
    btb_entry_buffer_pkg m_slot[N];
    int  m_wptr;
    int  m_stall;
    bit  m_hold;
    bit  m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < N; i++) m_slot[i] = '0;
            m_wptr  = 0;
            m_stall = 0;
            m_hold  = 1'b0;
        end else begin
            m_pop = (q.size() != 0) && btb_update_free;
            if (q.size() != 0 && !m_pop && !clear) begin
                m_stall++;
                m_hold = (m_stall == SM);
                if (m_hold) m_stall = 0;
            end else begin
                m_stall = 0;
                m_hold  = 1'b0;
            end
            if (clear) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (alloc_vld) begin
                    if (q.size() == N) void'(q.pop_front());
                    q.push_back(alloc_pld);
                    m_slot[m_wptr % N] = alloc_pld;
                    m_wptr = (m_wptr + 1) % (2 * N);
                end
            end
        end
    end

    logic [N-1:0] m_ena;
    int           m_sz;

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            m_sz  = q.size();
            m_ena = '0;
            for (int k = 0; k < m_sz; k++) m_ena[(m_wptr - m_sz + k + 2 * N) % N] = 1'b1;
            chk("mdl_req",   64'(btb_update_req),   64'(m_sz != 0));
            if (m_sz != 0) chk("mdl_head", 64'(btb_update_pld), 64'(q[0]));
            chk("mdl_count", 64'(count),            64'(m_sz));
            chk("mdl_ptr",   64'(entry_buffer_ptr), 64'(m_wptr));
            chk("mdl_ena",   64'(entry_buffer_ena), 64'(m_ena));
            chk("mdl_hold",  64'(pcgen_hold),       64'(m_hold));
            for (int i = 0; i < N; i++) chk("mdl_slot", 64'(entry_buffer_pld[i]), 64'(m_slot[i]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input btb_entry_buffer_pkg p);
        alloc_vld = 1'b1;
        alloc_pld = p;
        tick();
        alloc_vld = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req",   64'(btb_update_req),   64'd0);
        chk("rst_count", 64'(count),            64'd0);
        chk("rst_ena",   64'(entry_buffer_ena), 64'd0);
        chk("rst_ptr",   64'(entry_buffer_ptr), 64'd0);
        chk("rst_hold",  64'(pcgen_hold),       64'd0);
        chk("rst_slot0", 64'(entry_buffer_pld[0]), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // 1: idle after reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (20) tick();
        chk("t1_req",   64'(btb_update_req),   64'd0);
        chk("t1_ena",   64'(entry_buffer_ena), 64'b0000);
        chk("t1_ptr",   64'(entry_buffer_ptr), 64'd0);
        chk("t1_count", 64'(count),            64'd0);
        chk("t1_hold",  64'(pcgen_hold),       64'd0);

        // 2: push A,B(not taken),C then drain in order
        push(mk(10, 1'b1));
        push(mk(11, 1'b0));
        push(mk(12, 1'b1));
        chk("t2_ptr",   64'(entry_buffer_ptr), 64'd3);
        chk("t2_ena",   64'(entry_buffer_ena), 64'b0111);
        chk("t2_count", 64'(count),            64'd3);
        chk("t2_headA", 64'(btb_update_pld),   64'(mk(10, 1'b1)));
        btb_update_free = 1'b1;
        tick();
        chk("t2_headB", 64'(btb_update_pld),   64'(mk(11, 1'b0)));
        tick();
        chk("t2_headC", 64'(btb_update_pld),   64'(mk(12, 1'b1)));
        tick();
        chk("t2_req",   64'(btb_update_req),   64'd0);
        chk("t2_ena0",  64'(entry_buffer_ena), 64'd0);
        btb_update_free = 1'b0;

        // 3: overflow drops oldest
        do_reset();
        for (int k = 0; k < 5; k++) push(mk(20 + k, 1'b1));
        chk("t3_count", 64'(count),               64'd4);
        chk("t3_head",  64'(btb_update_pld),      64'(mk(21, 1'b1)));
        chk("t3_slot0", 64'(entry_buffer_pld[0]), 64'(mk(24, 1'b1)));
        chk("t3_ptr",   64'(entry_buffer_ptr),    64'b101);
        chk("t3_ena",   64'(entry_buffer_ena),    64'b1111);

        // 4: full with simultaneous push and pop, pointer wraps
        btb_update_free = 1'b1;
        push(mk(25, 1'b1));
        chk("t4_count1", 64'(count),            64'd4);
        chk("t4_head1",  64'(btb_update_pld),   64'(mk(22, 1'b1)));
        chk("t4_ptr1",   64'(entry_buffer_ptr), 64'd6);
        push(mk(26, 1'b1));
        push(mk(27, 1'b1));
        chk("t4_count3", 64'(count),            64'd4);
        chk("t4_head3",  64'(btb_update_pld),   64'(mk(24, 1'b1)));
        chk("t4_ptr3",   64'(entry_buffer_ptr), 64'd0);
        chk("t4_ena",    64'(entry_buffer_ena), 64'b1111);
        repeat (4) tick();
        chk("t4_drain",  64'(count),            64'd0);
        btb_update_free = 1'b0;

        // 5: starvation hold after exactly 8 stalled cycles
        push(mk(30, 1'b1));
        for (int k = 1; k <= SM; k++) begin
            tick();
            chk("t5_hold", 64'(pcgen_hold), 64'(k == SM));
        end
        btb_update_free = 1'b1;
        tick();
        chk("t5_hold_off", 64'(pcgen_hold),     64'd0);
        chk("t5_req",      64'(btb_update_req), 64'd0);
        chk("t5_count",    64'(count),          64'd0);
        btb_update_free = 1'b0;

        // 6: clear beats concurrent push
        push(mk(40, 1'b1));
        push(mk(41, 1'b1));
        push(mk(42, 1'b1));
        chk("t6_count3", 64'(count),            64'd3);
        chk("t6_ptr3",   64'(entry_buffer_ptr), 64'd4);
        clear     = 1'b1;
        alloc_vld = 1'b1;
        alloc_pld = mk(43, 1'b1);
        tick();
        clear     = 1'b0;
        alloc_vld = 1'b0;
        chk("t6_ena",   64'(entry_buffer_ena), 64'd0);
        chk("t6_count", 64'(count),            64'd0);
        chk("t6_ptr",   64'(entry_buffer_ptr), 64'd4);
        chk("t6_req",   64'(btb_update_req),   64'd0);

        // async reset mid-operation
        push(mk(50, 1'b1));
        push(mk(51, 1'b1));
        do_reset();
        repeat (4) tick();
        chk("post_rst_req", 64'(btb_update_req), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
